alu_nibble_seq: RTL

//  Sequencer that runs a 16-bit ALU operation through one external combinational
//  4-bit ALU slice, one nibble per clock, LS nibble first.

---
 rtl/alu_nibble_seq_if.sv | 42 ++++
 rtl/alu_nibble_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_nibble_seq_if.sv
// Operand/result and slice-facing signal bundle for alu_nibble_seq.
// Latency: none, wires only. Backpressure: none; the sequencer ignores start while busy.
// Optional flag outputs are carried regardless of ALU_FLAGS_EN.
interface alu_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [5:0]   c_in;
  logic         cin_in;

  logic [3:0]   slice_x;
  logic [3:0]   slice_y;
  logic [5:0]   slice_c;
  logic         slice_cin;
  logic [3:0]   slice_out;
  logic         slice_cout;

  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         flag_z;
  logic         flag_n;

  // Upstream requester plus the external slice
  modport master (
    output start, x_in, y_in, c_in, cin_in, slice_out, slice_cout,
    input  slice_x, slice_y, slice_c, slice_cin,
    input  busy, done, result, carry_out, flag_z, flag_n
  );

  // The sequencer
  modport slave (
    input  start, x_in, y_in, c_in, cin_in, slice_out, slice_cout,
    output slice_x, slice_y, slice_c, slice_cin,
    output busy, done, result, carry_out, flag_z, flag_n
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs a 4*NIBBLES-bit ALU op through one external 4-bit slice, LS nibble first; ALU_FLAGS_EN adds Z/N flags.
// Latency: NIBBLES clocks from start-accept edge to the one-cycle done pulse (NIBBLES+1 back-to-back).
// Backpressure: start is only accepted when not busy; a start during busy is dropped.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_nibble_seq_if.slave io
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [W-1:0]  x_reg;
  logic [W-1:0]  y_reg;
  logic [W-1:0]  result_reg;
  logic [W-1:0]  next_result;
  logic [5:0]    c_reg;
  logic          carry_reg;
  logic          carry_out_reg;
  logic [IW-1:0] idx;
  logic          accept;
  logic          running;
  logic          last;

  assign running = (state == RUN);
  assign accept  = io.start && !running;
  assign last    = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (io.start) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = io.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The slice output lands in the current nibble; the rest of the word is kept
  always_comb begin
    next_result = result_reg;
    next_result[4*idx +: 4] = io.slice_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg         <= '0;
      y_reg         <= '0;
      c_reg         <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      result_reg    <= '0;
      idx           <= '0;
    end else if (accept) begin
      x_reg     <= io.x_in;
      y_reg     <= io.y_in;
      c_reg     <= io.c_in;
      carry_reg <= io.cin_in;
      idx       <= '0;
    end else if (running) begin
      result_reg <= next_result;
      carry_reg  <= io.slice_cout;
      idx        <= last ? '0 : idx + 1'b1;
      if (last) carry_out_reg <= io.slice_cout;
    end
  end

  assign io.slice_x   = running ? x_reg[4*idx +: 4] : 4'h0;
  assign io.slice_y   = running ? y_reg[4*idx +: 4] : 4'h0;
  assign io.slice_cin = running ? carry_reg : 1'b0;
  assign io.slice_c   = c_reg;

  assign io.busy      = running;
  assign io.done      = (state == DONE);
  assign io.result    = result_reg;
  assign io.carry_out = carry_out_reg;

`ifdef ALU_FLAGS_EN
  logic flag_z_reg;
  logic flag_n_reg;

  // Flags are taken from the completed word in the same edge as the final nibble
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
    end else if (running && last) begin
      flag_z_reg <= (next_result == '0);
      flag_n_reg <= next_result[W-1];
    end
  end

  assign io.flag_z = flag_z_reg;
  assign io.flag_n = flag_n_reg;
`else
  assign io.flag_z = 1'b0;
  assign io.flag_n = 1'b0;
`endif
endmodule
